// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: two-master round-robin Wishbone arbiter in front of the single SDRAM slave
// Ports: sys_clk/sys_rst (async, active-high); m0_*/m1_* master sides (cyc, stb, we, adr, dat_ms, sel,
// cti, bte in; dat_sm, ack, err, rty out); s_* slave side; gnt one-hot grant (00 = idle);
// wd_fault sticky watchdog flag. Optional watchdog enabled by defining ARB_WATCHDOG_EN.
module wshb_rr_arbiter #(
  parameter int ADR_W = 32
`ifdef ARB_WATCHDOG_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [31:0]      m0_dat_ms,
  input  logic [3:0]       m0_sel,
  input  logic [2:0]       m0_cti,
  input  logic [1:0]       m0_bte,
  output logic [31:0]      m0_dat_sm,
  output logic             m0_ack,
  output logic             m0_err,
  output logic             m0_rty,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [31:0]      m1_dat_ms,
  input  logic [3:0]       m1_sel,
  input  logic [2:0]       m1_cti,
  input  logic [1:0]       m1_bte,
  output logic [31:0]      m1_dat_sm,
  output logic             m1_ack,
  output logic             m1_err,
  output logic             m1_rty,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [31:0]      s_dat_ms,
  output logic [3:0]       s_sel,
  output logic [2:0]       s_cti,
  output logic [1:0]       s_bte,
  input  logic [31:0]      s_dat_sm,
  input  logic             s_ack,
  input  logic             s_err,
  input  logic             s_rty,
  output logic [1:0]       gnt,
  output logic             wd_fault
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_nx;
  logic last, last_nx;
  logic sel0, sel1, stb_g, wd_hit;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  // A burst ends only when the owner drops cyc; a waiting master is handed over on that same edge.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: state_nx = (m0_cyc & m1_cyc) ? (last ? G0 : G1) : m0_cyc ? G0 : m1_cyc ? G1 : IDLE;
      G0: if (!m0_cyc) begin
        last_nx  = 1'b0;
        state_nx = m1_cyc ? G1 : IDLE;
      end
      G1: if (!m1_cyc) begin
        last_nx  = 1'b1;
        state_nx = m0_cyc ? G0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign sel0  = state == G0;
  assign sel1  = state == G1;
  assign gnt   = {sel1, sel0};
  assign stb_g = (sel0 & m0_stb) | (sel1 & m1_stb);
  // A watchdog expiry withdraws cyc/stb from the slave for the cycle the error is reported.
  assign s_cyc    = ((sel0 & m0_cyc) | (sel1 & m1_cyc)) & ~wd_hit;
  assign s_stb    = stb_g & ~wd_hit;
  assign s_we     = (sel0 & m0_we) | (sel1 & m1_we);
  assign s_adr    = sel0 ? m0_adr : sel1 ? m1_adr : '0;
  assign s_dat_ms = sel0 ? m0_dat_ms : sel1 ? m1_dat_ms : '0;
  assign s_sel    = sel0 ? m0_sel : sel1 ? m1_sel : '0;
  assign s_cti    = sel0 ? m0_cti : sel1 ? m1_cti : '0;
  assign s_bte    = sel0 ? m0_bte : sel1 ? m1_bte : '0;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign m0_ack = sel0 & s_ack;
  assign m1_ack = sel1 & s_ack;
  assign m0_err = sel0 & (s_err | wd_hit);
  assign m1_err = sel1 & (s_err | wd_hit);
  assign m0_rty = sel0 & s_rty;
  assign m1_rty = sel1 & s_rty;
`ifdef ARB_WATCHDOG_EN
  logic [7:0] cnt;
  logic fault;
  logic term;
  assign term   = s_ack | s_err | s_rty;
  assign wd_hit = (sel0 | sel1) && cnt == 8'(TIMEOUT);
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      cnt   <= (state_nx != state || state == IDLE || term || wd_hit) ? '0 : cnt + {7'd0, stb_g};
      fault <= fault | wd_hit;
    end
  assign wd_fault = fault;
`else
  assign wd_hit   = 1'b0;
  assign wd_fault = 1'b0;
`endif
endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb_wshb_rr_arbiter: scoreboard bench for the two-master round-robin arbiter
module tb_wshb_rr_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [1:0] cyc = 2'b11, stb = 2'b00, we = 2'b00;
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [31:0] m0_dat_sm, m1_dat_sm, s_dat_ms, s_adr, s_dat_sm;
  logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty, wd_fault, ack_en;
  logic [3:0] s_sel;
  logic [2:0] s_cti;
  logic [1:0] s_bte, gnt;
  typedef struct {logic [1:0] g; logic [31:0] a; logic [31:0] d; logic w;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  localparam logic [31:0] WMASK = 32'h5A5A_0000, RMASK = 32'hC0DE_0000;
  always #5 sys_clk = ~sys_clk;
  assign s_ack    = ack_en & s_cyc & s_stb;
  assign s_err    = 1'b0;
  assign s_rty    = 1'b0;
  assign s_dat_sm = s_adr ^ RMASK;
  wshb_rr_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(cyc[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_adr(adr[0]), .m0_dat_ms(dat[0]),
    .m0_sel(4'hF), .m0_cti(3'd0), .m0_bte(2'd0), .m0_dat_sm(m0_dat_sm),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
    .m1_cyc(cyc[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_adr(adr[1]), .m1_dat_ms(dat[1]),
    .m1_sel(4'h3), .m1_cti(3'd0), .m1_bte(2'd0), .m1_dat_sm(m1_dat_sm),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_dat_sm(s_dat_sm),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .gnt(gnt), .wd_fault(wd_fault)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [1:0] g, input logic [31:0] base, input int beats, input logic w);
    for (int i = 0; i < beats; i++)
      exp_q.push_back('{g, base + 32'(4 * i), (base + 32'(4 * i)) ^ WMASK, w});
  endtask
  task automatic burst(input int n, input int beats, input logic [31:0] base, input logic w);
    int b = 0;
    int g = 0;
    cyc[n] = 1'b1;
    stb[n] = 1'b1;
    we[n]  = w;
    adr[n] = base;
    dat[n] = base ^ WMASK;
    while (b < beats && g < 400) begin
      @(negedge sys_clk);
      g++;
      if (n == 0 ? m0_ack : m1_ack) begin
        b++;
        @(posedge sys_clk);
        #1;
        adr[n] = base + 32'(4 * b);
        dat[n] = adr[n] ^ WMASK;
      end
    end
    chk($sformatf("burst_done_m%0d", n), 32'(b), 32'(beats));
    cyc[n] = 1'b0;
    stb[n] = 1'b0;
    we[n]  = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(negedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (s_cyc && s_stb && s_ack) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {30'd0, gnt}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("beat_gnt", {30'd0, gnt}, {30'd0, e.g});
        chk("beat_ack_route", {30'd0, m1_ack, m0_ack}, {30'd0, e.g});
        chk("beat_adr", s_adr, e.a);
        chk("beat_we", {31'd0, s_we}, {31'd0, e.w});
        if (e.w) chk("beat_wdata", s_dat_ms, e.d);
        else begin
          chk("beat_rdata_m0", m0_dat_sm, e.a ^ RMASK);
          chk("beat_rdata_m1", m1_dat_sm, e.a ^ RMASK);
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    adr[0] = '0; adr[1] = '0; dat[0] = '0; dat[1] = '0;
    ack_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_scyc", {31'd0, s_cyc}, 32'd0);
    chk("rst_term", {28'd0, m1_ack, m0_ack, m1_err, m0_err}, 32'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rel_gnt_idle", {30'd0, gnt}, 32'd0);
    @(negedge sys_clk);
    chk("rel_gnt_m0", {30'd0, gnt}, 32'd1);
    chk("rel_scyc", {31'd0, s_cyc}, 32'd1);
    cyc = 2'b00;
    do_reset();
    push(2'b01, 32'h100, 4, 1'b1);
    push(2'b10, 32'h400, 4, 1'b0);
    push(2'b01, 32'h200, 4, 1'b0);
    push(2'b10, 32'h500, 4, 1'b1);
    fork
      begin burst(0, 4, 32'h100, 1'b1); @(posedge sys_clk); #1; burst(0, 4, 32'h200, 1'b0); end
      begin burst(1, 4, 32'h400, 1'b0); @(posedge sys_clk); #1; burst(1, 4, 32'h500, 1'b1); end
      begin
        int idle = 0;
        int g = 0;
        @(posedge sys_clk);
        #1;
        while ((cyc[0] || cyc[1]) && g < 300) begin
          @(negedge sys_clk);
          g++;
          if (gnt == 2'b00 || gnt == 2'b11) idle++;
        end
        chk("rr_no_idle_gnt", 32'(idle), 32'd0);
      end
    join
    push(2'b01, 32'h1000, 8, 1'b0);
    burst(0, 8, 32'h1000, 1'b0);
    push(2'b10, 32'h2000, 4, 1'b1);
    push(2'b01, 32'h3000, 2, 1'b0);
    fork
      burst(1, 4, 32'h2000, 1'b1);
      begin repeat (2) @(negedge sys_clk); burst(0, 2, 32'h3000, 1'b0); end
      begin
        int g = 0;
        int early = 0;
        #1;
        while (cyc[1] && g < 200) begin
          @(negedge sys_clk);
          g++;
          if (m0_ack) early++;
        end
        chk("stall_no_m0_ack", 32'(early), 32'd0);
        chk("handover_gnt_m1", {30'd0, gnt}, 32'd2);
        @(negedge sys_clk);
        chk("handover_gnt_m0", {30'd0, gnt}, 32'd1);
      end
    join
    ack_en = 1'b0;
    adr[0] = 32'h4000;
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("pre_rst_gnt", {30'd0, gnt}, 32'd1);
    chk("pre_rst_scyc", {31'd0, s_cyc}, 32'd1);
    cyc[1] = 1'b1;
    #2 sys_rst = 1'b1;
    #1;
    chk("mid_rst_scyc", {31'd0, s_cyc}, 32'd0);
    chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("post_rst_idle", {30'd0, gnt}, 32'd0);
    @(negedge sys_clk);
    chk("post_rst_gnt_m0", {30'd0, gnt}, 32'd1);
    cyc = 2'b00;
    stb = 2'b00;
    @(posedge sys_clk);
    #1 ack_en = 1'b1;
`ifdef ARB_WATCHDOG_EN
    begin
      int k = 0;
      int first = -1;
      int hit = -1;
      logic cyc_at_hit = 1'b1;
      do_reset();
      ack_en = 1'b0;
      adr[0] = 32'h6000;
      cyc[0] = 1'b1;
      stb[0] = 1'b1;
      while (hit < 0 && k < 600) begin
        @(negedge sys_clk);
        k++;
        if (s_stb && first < 0) first = k;
        if (m0_err) begin
          hit = k;
          cyc_at_hit = s_cyc;
        end
      end
      chk("wd_delay", 32'(hit - first), 32'd255);
      chk("wd_scyc_forced", {31'd0, cyc_at_hit}, 32'd0);
      @(negedge sys_clk);
      chk("wd_err_one_clk", {31'd0, m0_err}, 32'd0);
      chk("wd_fault_set", {31'd0, wd_fault}, 32'd1);
      cyc[0] = 1'b0;
      stb[0] = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("wd_fault_sticky", {31'd0, wd_fault}, 32'd1);
      do_reset();
      @(negedge sys_clk);
      chk("wd_fault_cleared", {31'd0, wd_fault}, 32'd0);
      ack_en = 1'b1;
    end
`else
    chk("wd_fault_off", {31'd0, wd_fault}, 32'd0);
`endif
    repeat (2) @(negedge sys_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
